// File: rtl/tri_addrcmp_tbl.sv
// tri_addrcmp_tbl: small registered table of 36-bit compare addresses.
// Allocate / deallocate / flush-walk on the write side; one-cycle pipelined
// lookup returning hit, lowest hit index and multi-hit on the read side.
// Bit 35 of an entry takes part in the compare only when its lsb_en is set.
// Optional feature macro: TRI_ADDRCMP_TBL_PARITY_EN (per-entry even parity over
// {addr, lsb_en}; a matching entry with bad parity raises perr, is dropped from
// the result and is invalidated).
module tri_addrcmp_tbl #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned IDXW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_val,
    input  logic [0:35]     alloc_addr,
    input  logic            alloc_lsb_en,
    output logic            alloc_rdy,
    output logic [0:IDXW-1] alloc_idx,
    input  logic            dealloc_val,
    input  logic [0:IDXW-1] dealloc_idx,
    input  logic            flush_req,
    output logic            flush_busy,
    input  logic            lkup_val,
    input  logic [0:35]     lkup_addr,
    output logic            hit_val,
    output logic            hit,
    output logic [0:IDXW-1] hit_idx,
    output logic            hit_multi,
    output logic [0:IDXW]   count,
    output logic            full,
    output logic            empty,
    output logic            perr
);

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } flush_state_e;

    flush_state_e state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            flush_busy_q, flush_busy_d;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [0:35]        addr_q [ENTRIES];
    logic [ENTRIES-1:0] lsb_en_q;
    logic [IDXW:0]      count_q, count_d;

    logic            hit_val_q, hit_val_d;
    logic            hit_q, hit_d;
    logic [IDXW-1:0] hit_idx_q, hit_idx_d;
    logic            hit_multi_q, hit_multi_d;
    logic            perr_q, perr_d;

    logic [IDXW-1:0]    alloc_sel;
    logic               alloc_acc;
    logic               full_int;
    logic [ENTRIES-1:0] match;
    logic [ENTRIES-1:0] par_err;
    logic [ENTRIES-1:0] good;
    logic [ENTRIES-1:0] clr;
    logic [IDXW:0]      clr_cnt;

    assign full_int  = (count_q == (IDXW + 1)'(ENTRIES));
    assign alloc_rdy = ~full_int & ~flush_busy_q;
    assign alloc_acc = alloc_val & alloc_rdy;

    // Lowest free entry, taken from the pre-dealloc valid set so a freed slot
    // is never reused in the same cycle.
    always_comb begin
        alloc_sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_sel = IDXW'(i);
            end
        end
    end

    assign alloc_idx = alloc_sel;

    // Stage-0 compare against pre-edge table contents.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = lkup_val & valid_q[i]
                     & (addr_q[i][0:34] == lkup_addr[0:34])
                     & (~lsb_en_q[i] | (addr_q[i][35] == lkup_addr[35]));
        end
    end

`ifdef TRI_ADDRCMP_TBL_PARITY_EN
    logic [ENTRIES-1:0] par_q;

    // Parity storage, written alongside the address; not reset.
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            par_q[alloc_sel] <= ^{alloc_addr, alloc_lsb_en};
        end
    end

    // Only entries that actually matched are parity-checked.
    always_comb begin
        par_err = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            par_err[i] = match[i] & ((^{addr_q[i], lsb_en_q[i]}) != par_q[i]);
        end
    end
`else
    assign par_err = '0;
`endif

    assign good = match & ~par_err;

    // Stage-1 result: lowest good match and whether more than one matched.
    always_comb begin
        hit_val_d   = lkup_val;
        hit_d       = 1'b0;
        hit_idx_d   = '0;
        hit_multi_d = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (good[i]) begin
                if (hit_d) begin
                    hit_multi_d = 1'b1;
                end else begin
                    hit_d     = 1'b1;
                    hit_idx_d = IDXW'(i);
                end
            end
        end
        perr_d = |par_err;
    end

    // Flush walk next-state: one entry per cycle, ENTRIES cycles in total.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (flush_req) begin
                    state_d = StFlush;
                    ptr_d   = '0;
                end
            end
            StFlush: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDXW'(ENTRIES - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        flush_busy_d = (state_d == StFlush);
    end

    // Valid/count next-state; overlapping clears of one entry count once.
    always_comb begin
        clr = '0;
        if (dealloc_val) begin
            clr[dealloc_idx] = 1'b1;
        end
        if (state_q == StFlush) begin
            clr[ptr_q] = 1'b1;
        end
        clr = (clr | par_err) & valid_q;

        valid_d = valid_q & ~clr;
        if (alloc_acc) begin
            valid_d[alloc_sel] = 1'b1;
        end

        clr_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            clr_cnt = clr_cnt + (IDXW + 1)'(clr[i]);
        end
        count_d = count_q + (IDXW + 1)'(alloc_acc) - clr_cnt;
    end

    // Control state and pipeline registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            flush_busy_q <= 1'b0;
            valid_q      <= '0;
            count_q      <= '0;
            hit_val_q    <= 1'b0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            hit_multi_q  <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            flush_busy_q <= flush_busy_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            hit_val_q    <= hit_val_d;
            hit_q        <= hit_d;
            hit_idx_q    <= hit_idx_d;
            hit_multi_q  <= hit_multi_d;
            perr_q       <= perr_d;
        end
    end

    // Address and lsb_en payload storage; not reset.
    always_ff @(posedge clk) begin
        if (alloc_acc) begin
            addr_q[alloc_sel]   <= alloc_addr;
            lsb_en_q[alloc_sel] <= alloc_lsb_en;
        end
    end

    assign flush_busy = flush_busy_q;
    assign hit_val    = hit_val_q;
    assign hit        = hit_q;
    assign hit_idx    = hit_idx_q;
    assign hit_multi  = hit_multi_q;
    assign perr       = perr_q;
    assign count      = count_q;
    assign full       = full_int;
    assign empty      = (count_q == '0);

endmodule
